// File: rtl/conv_window_ctrl_pkg.sv
// Shared definitions for the convolution window sequencer and the line-buffer chain.
package cnn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int IMG_WIDTH_DEF  = 482;
   localparam int IMG_HEIGHT_DEF = 482;
   localparam int KSIZE_DEF      = 3;
   localparam int STRIDE_DEF     = 1;
   localparam int CNT_W_DEF      = 9;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel handshake, line-buffer control and status bundle between the scheduler and the sequencer.
interface conv_window_ctrl_if
   import cnn_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF);

   logic             start;
   logic             abort;
   logic             pix_valid;
   logic             pix_ready;
   logic             lb_wr_en;
   logic             win_valid;
   logic [CNT_W-1:0] row_idx;
   logic [CNT_W-1:0] col_idx;
   logic             busy;
   logic             frame_done;

   modport master (
      output start, abort, pix_valid,
      input  pix_ready, lb_wr_en, win_valid, row_idx, col_idx, busy, frame_done
   );

   modport slave (
      input  start, abort, pix_valid,
      output pix_ready, lb_wr_en, win_valid, row_idx, col_idx, busy, frame_done
   );

endinterface

// File: rtl/conv_window_ctrl_raster_counter.sv
// Raster position tracker: column/row counters with wrap, end-of-row/frame flags and
// stride phase counters that restart at the first position able to complete a window.
module raster_counter
   import cnn_pkg::*;
   #(
      parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
      parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
      parameter int KSIZE      = KSIZE_DEF,
      parameter int STRIDE     = STRIDE_DEF,
      parameter int CNT_W      = CNT_W_DEF
   )
   (
      input  logic             clk,
      input  logic             rst_n,
      input  logic             clr,
      input  logic             adv,
      output logic [CNT_W-1:0] col,
      output logic [CNT_W-1:0] row,
      output logic [CNT_W-1:0] col_phase,
      output logic [CNT_W-1:0] row_phase,
      output logic             end_of_row,
      output logic             end_of_frame
   );

   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_COL    = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAST_ROW    = CNT_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] PHASE_START = CNT_W'(KSIZE - 1);
   localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(STRIDE - 1);

   logic [CNT_W-1:0] col_nxt;
   logic [CNT_W-1:0] row_nxt;
   logic [CNT_W-1:0] col_phase_nxt;
   logic [CNT_W-1:0] row_phase_nxt;

   assign end_of_row   = (col == LAST_COL);
   assign end_of_frame = end_of_row && (row == LAST_ROW);

   // Next position and phases; phases count modulo STRIDE by compare-and-clear, no divider.
   always_comb begin
      col_nxt       = end_of_row ? '0 : col + ONE;
      row_nxt       = row;
      col_phase_nxt = '0;
      row_phase_nxt = row_phase;
      if (end_of_row) begin
         row_nxt = end_of_frame ? '0 : row + ONE;
      end
      if (col_nxt != PHASE_START && col_phase != PHASE_LAST) begin
         col_phase_nxt = col_phase + ONE;
      end
      if (end_of_row) begin
         if (row_nxt == PHASE_START || row_phase == PHASE_LAST) begin
            row_phase_nxt = '0;
         end else begin
            row_phase_nxt = row_phase + ONE;
         end
      end
   end

   // Position registers advance once per accepted pixel; clr restarts the raster.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         col_phase <= '0;
         row_phase <= '0;
      end else if (clr) begin
         col       <= '0;
         row       <= '0;
         col_phase <= '0;
         row_phase <= '0;
      end else if (adv) begin
         col       <= col_nxt;
         row       <= row_nxt;
         col_phase <= col_phase_nxt;
         row_phase <= row_phase_nxt;
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer chain sequencer: gates pixel writes, tracks raster position and flags
// shifts that complete a full (unpadded) window at the configured stride.
module conv_window_ctrl
   import cnn_pkg::*;
   #(
      parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
      parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
      parameter int KSIZE      = KSIZE_DEF,
      parameter int STRIDE     = STRIDE_DEF,
      parameter int CNT_W      = CNT_W_DEF
   )
   (
      input logic               clk,
      input logic               rst_n,
      conv_window_ctrl_if.slave bus
   );

   localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(KSIZE - 1);
   localparam logic [CNT_W-1:0] FILL_ROW  = CNT_W'(KSIZE - 2);

   state_t           state_q;
   state_t           state_d;
   logic             ready;
   logic             accept;
   logic             qualify;
   logic [CNT_W-1:0] col;
   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] col_phase;
   logic [CNT_W-1:0] row_phase;
   logic             end_of_row;
   logic             end_of_frame;

   raster_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .KSIZE      (KSIZE),
      .STRIDE     (STRIDE),
      .CNT_W      (CNT_W)
   ) u_raster (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (bus.abort),
      .adv          (accept),
      .col          (col),
      .row          (row),
      .col_phase    (col_phase),
      .row_phase    (row_phase),
      .end_of_row   (end_of_row),
      .end_of_frame (end_of_frame)
   );

   // Handshake: abort beats a pixel in the same cycle so a cancelled pixel never reaches the chain.
   assign ready          = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign accept         = bus.pix_valid && ready && !bus.abort;
   assign bus.pix_ready  = ready;
   assign bus.lb_wr_en   = accept;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.frame_done = (state_q == ST_DONE);
   assign qualify        = (row >= WIN_FIRST) && (col >= WIN_FIRST) &&
                           (col_phase == '0) && (row_phase == '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: FILL primes KSIZE-1 rows, RUN produces windows, DONE is a single-cycle tail.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.start && !bus.abort) state_d = ST_FILL;
         ST_FILL: begin
            if (bus.abort)                                      state_d = ST_IDLE;
            else if (accept && end_of_row && row == FILL_ROW)   state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.abort)                   state_d = ST_IDLE;
            else if (accept && end_of_frame) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Position and window flag are registered so they line up with the window register shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.win_valid <= 1'b0;
         bus.row_idx   <= '0;
         bus.col_idx   <= '0;
      end else if (bus.abort) begin
         bus.win_valid <= 1'b0;
         bus.row_idx   <= '0;
         bus.col_idx   <= '0;
      end else begin
         bus.win_valid <= accept && qualify;
         if (accept) begin
            bus.row_idx <= row;
            bus.col_idx <= col;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on a 6x5 frame, K=3, with a STRIDE=1 and a STRIDE=2 instance.
module tb_conv_window_ctrl;

   localparam int CW = 9;

   logic clk;
   logic rst_n;
   logic start;
   logic abort;
   logic pix_valid;
   logic clr_mon;

   int n_checks;
   int n_fail;

   conv_window_ctrl_if #(.CNT_W(CW)) if1 ();
   conv_window_ctrl_if #(.CNT_W(CW)) if2 ();

   assign if1.start     = start;
   assign if1.abort     = abort;
   assign if1.pix_valid = pix_valid;
   assign if2.start     = start;
   assign if2.abort     = abort;
   assign if2.pix_valid = pix_valid;

   conv_window_ctrl #(.IMG_WIDTH(6), .IMG_HEIGHT(5), .KSIZE(3), .STRIDE(1), .CNT_W(CW))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   conv_window_ctrl #(.IMG_WIDTH(6), .IMG_HEIGHT(5), .KSIZE(3), .STRIDE(2), .CNT_W(CW))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observation counters, sampled on the falling edge.
   int wr1, win1, done1, wr_at_done1, first_win_wr1, gap_err, wr2, win2;
   logic prev_wr1, prev_wr_at_done1;
   logic [CW-1:0] win_r1 [0:15];
   logic [CW-1:0] win_c1 [0:15];
   logic [CW-1:0] win_r2 [0:15];
   logic [CW-1:0] win_c2 [0:15];

   always @(negedge clk) begin
      if (clr_mon) begin
         wr1 <= 0; win1 <= 0; done1 <= 0; wr_at_done1 <= -1; first_win_wr1 <= -1;
         gap_err <= 0; wr2 <= 0; win2 <= 0; prev_wr1 <= 1'b0; prev_wr_at_done1 <= 1'b0;
      end else begin
         if (if1.win_valid) begin
            if (win1 == 0) first_win_wr1 <= wr1;
            if (win1 < 16) begin
               win_r1[win1] <= if1.row_idx;
               win_c1[win1] <= if1.col_idx;
            end
            win1 <= win1 + 1;
         end
         if (if1.frame_done) begin
            done1            <= done1 + 1;
            wr_at_done1      <= wr1;
            prev_wr_at_done1 <= prev_wr1;
         end
         if (if1.lb_wr_en) wr1 <= wr1 + 1;
         if (if1.lb_wr_en && !pix_valid) gap_err <= gap_err + 1;
         prev_wr1 <= if1.lb_wr_en;
         if (if2.win_valid) begin
            if (win2 < 16) begin
               win_r2[win2] <= if2.row_idx;
               win_c2[win2] <= if2.col_idx;
            end
            win2 <= win2 + 1;
         end
         if (if2.lb_wr_en) wr2 <= wr2 + 1;
      end
   end

   task automatic clear_mon();
      clr_mon = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      clr_mon = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      pix_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drive pixels until n writes have been observed; optionally re-pulse start at a given count.
   task automatic drive_until_wr(input int n, input bit gaps, input int restart_at, output bit ok);
      ok = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         start = (restart_at >= 0) && (wr1 == restart_at);
         if (wr1 >= n) begin
            pix_valid = 1'b0;
            start = 1'b0;
            ok = 1'b1;
            break;
         end
         pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      pix_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({if1.pix_ready, if1.lb_wr_en, if1.win_valid, if1.busy, if1.frame_done} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000",
                  {if1.pix_ready, if1.lb_wr_en, if1.win_valid, if1.busy, if1.frame_done});
      end
      n_checks++;
      if (if1.row_idx !== '0 || if1.col_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_idx: got row %0d col %0d want 0 0", if1.row_idx, if1.col_idx);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      pix_valid = 1'b0;
   endtask

   task automatic test_frame();
      bit ok;
      int k;
      clear_mon();
      pulse_start();
      drive_until_wr(30, 1'b0, -1, ok);
      repeat (4) @(posedge clk); #1;
      n_checks++; if (!ok)          begin n_fail++; $display("FAIL frame_timeout: got %0d want 1", ok); end
      n_checks++; if (wr1 != 30)    begin n_fail++; $display("FAIL frame_wr: got %0d want 30", wr1); end
      n_checks++; if (win1 != 12)   begin n_fail++; $display("FAIL frame_wins: got %0d want 12", win1); end
      n_checks++; if (first_win_wr1 != 15) begin n_fail++; $display("FAIL first_win_after: got %0d writes want 15", first_win_wr1); end
      n_checks++; if (done1 != 1)   begin n_fail++; $display("FAIL frame_done_cnt: got %0d want 1", done1); end
      n_checks++; if (wr_at_done1 != 30 || prev_wr_at_done1 !== 1'b1) begin
         n_fail++; $display("FAIL frame_done_time: got wr %0d prev %0d want 30 1", wr_at_done1, prev_wr_at_done1);
      end
      n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL frame_idle: busy %0d want 0", if1.busy); end
      k = 0;
      for (int r = 2; r <= 4; r++) begin
         for (int c = 2; c <= 5; c++) begin
            n_checks++;
            if (win_r1[k] !== CW'(r) || win_c1[k] !== CW'(c)) begin
               n_fail++;
               $display("FAIL frame_win_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, win_r1[k], win_c1[k], r, c);
            end
            k++;
         end
      end
      n_checks++; if (wr2 != 30)    begin n_fail++; $display("FAIL s2_wr: got %0d want 30", wr2); end
      n_checks++; if (win2 != 4)    begin n_fail++; $display("FAIL s2_wins: got %0d want 4", win2); end
      k = 0;
      for (int r = 2; r <= 4; r += 2) begin
         for (int c = 2; c <= 4; c += 2) begin
            n_checks++;
            if (win_r2[k] !== CW'(r) || win_c2[k] !== CW'(c)) begin
               n_fail++;
               $display("FAIL s2_win_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, win_r2[k], win_c2[k], r, c);
            end
            k++;
         end
      end
   endtask

   task automatic test_gaps();
      bit ok;
      int k;
      clear_mon();
      pulse_start();
      drive_until_wr(30, 1'b1, -1, ok);
      repeat (4) @(posedge clk); #1;
      n_checks++; if (!ok)         begin n_fail++; $display("FAIL gap_timeout: got %0d want 1", ok); end
      n_checks++; if (wr1 != 30)   begin n_fail++; $display("FAIL gap_wr: got %0d want 30", wr1); end
      n_checks++; if (win1 != 12)  begin n_fail++; $display("FAIL gap_wins: got %0d want 12", win1); end
      n_checks++; if (gap_err != 0) begin n_fail++; $display("FAIL gap_write: got %0d want 0", gap_err); end
      n_checks++; if (done1 != 1)  begin n_fail++; $display("FAIL gap_done: got %0d want 1", done1); end
      k = 0;
      for (int r = 2; r <= 4; r++) begin
         for (int c = 2; c <= 5; c++) begin
            n_checks++;
            if (win_r1[k] !== CW'(r) || win_c1[k] !== CW'(c)) begin
               n_fail++;
               $display("FAIL gap_win_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, win_r1[k], win_c1[k], r, c);
            end
            k++;
         end
      end
   endtask

   task automatic test_idle_restart();
      bit ok;
      clear_mon();
      pix_valid = 1'b1;
      repeat (6) @(posedge clk); #1;
      pix_valid = 1'b0;
      n_checks++; if (wr1 != 0)        begin n_fail++; $display("FAIL idle_wr: got %0d want 0", wr1); end
      n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0d want 0", if1.busy); end
      pulse_start();
      drive_until_wr(30, 1'b0, 10, ok);
      repeat (4) @(posedge clk); #1;
      n_checks++; if (!ok)        begin n_fail++; $display("FAIL restart_timeout: got %0d want 1", ok); end
      n_checks++; if (wr1 != 30)  begin n_fail++; $display("FAIL restart_wr: got %0d want 30", wr1); end
      n_checks++; if (win1 != 12) begin n_fail++; $display("FAIL restart_wins: got %0d want 12", win1); end
      n_checks++; if (done1 != 1 || wr_at_done1 != 30) begin
         n_fail++; $display("FAIL restart_done: got cnt %0d at wr %0d want 1 at 30", done1, wr_at_done1);
      end
   endtask

   task automatic test_abort();
      bit ok;
      clear_mon();
      pulse_start();
      drive_until_wr(17, 1'b0, -1, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: got %0d want 1", ok); end
      abort = 1'b1;
      pix_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (if1.lb_wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_write: got %0d want 0", if1.lb_wr_en); end
      @(posedge clk); #1;
      abort = 1'b0;
      pix_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({if1.busy, if1.pix_ready, if1.win_valid} !== 3'b0) begin
         n_fail++; $display("FAIL abort_idle: got %b want 000", {if1.busy, if1.pix_ready, if1.win_valid});
      end
      n_checks++; if (if1.row_idx !== '0 || if1.col_idx !== '0) begin
         n_fail++; $display("FAIL abort_idx: got row %0d col %0d want 0 0", if1.row_idx, if1.col_idx);
      end
      repeat (4) @(posedge clk); #1;
      n_checks++; if (wr1 != 17)  begin n_fail++; $display("FAIL abort_wr: got %0d want 17", wr1); end
      n_checks++; if (win1 != 3)  begin n_fail++; $display("FAIL abort_wins: got %0d want 3", win1); end
      n_checks++; if (done1 != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done1); end
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int k;
      clear_mon();
      pulse_start();
      drive_until_wr(20, 1'b0, -1, ok);
      pix_valid = 1'b1;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({if1.pix_ready, if1.lb_wr_en, if1.win_valid, if1.busy, if1.frame_done} !== 5'b0 ||
             if1.row_idx !== '0 || if1.col_idx !== '0) begin
            n_fail++;
            $display("FAIL midreset_out[%0d]: got flags %b row %0d col %0d want 0", i,
                     {if1.pix_ready, if1.lb_wr_en, if1.win_valid, if1.busy, if1.frame_done},
                     if1.row_idx, if1.col_idx);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      pix_valid = 1'b0;
      clear_mon();
      pulse_start();
      drive_until_wr(30, 1'b0, -1, ok);
      repeat (4) @(posedge clk); #1;
      n_checks++; if (!ok)        begin n_fail++; $display("FAIL refill_timeout: got %0d want 1", ok); end
      n_checks++; if (wr1 != 30)  begin n_fail++; $display("FAIL refill_wr: got %0d want 30", wr1); end
      n_checks++; if (win1 != 12) begin n_fail++; $display("FAIL refill_wins: got %0d want 12", win1); end
      n_checks++; if (done1 != 1) begin n_fail++; $display("FAIL refill_done: got %0d want 1", done1); end
      k = 0;
      for (int r = 2; r <= 4; r++) begin
         for (int c = 2; c <= 5; c++) begin
            n_checks++;
            if (win_r1[k] !== CW'(r) || win_c1[k] !== CW'(c)) begin
               n_fail++;
               $display("FAIL refill_win_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", k, win_r1[k], win_c1[k], r, c);
            end
            k++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clr_mon  = 1'b1;
      test_reset();
      test_frame();
      test_gaps();
      test_idle_restart();
      test_abort();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencer for the cascaded line-buffer chain (KSIZE-1 line FIFOs plus a KSIZE x KSIZE window register) that feeds the systolic-array convolution core.
- Accepts a raster pixel stream for one frame and gates line-buffer writes.
- Tracks the row and column position, and marks which shifted-in positions complete a valid (no padding) convolution window at the configured stride.
- Signals frame completion to the layer scheduler.

Parameters:
- IMG_WIDTH, 482, pixels per row.
- IMG_HEIGHT, 482, rows per frame.
- KSIZE, 3, kernel edge; the chain holds KSIZE-1 line buffers.
- STRIDE, 1, window stride in both dimensions (1..KSIZE).
- CNT_W, 9, counter width; must satisfy 2^CNT_W > max(IMG_WIDTH, IMG_HEIGHT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- abort  in  1  synchronous frame cancel
- pix_valid  in  1  upstream pixel strobe
- pix_ready  out  1  controller accepts pixels
- lb_wr_en  out  1  write/shift enable to line-buffer chain and window register
- win_valid  out  1  window register holds a valid window this cycle
- row_idx  out  CNT_W  row of last accepted pixel
- col_idx  out  CNT_W  column of last accepted pixel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame: the frame is discarded immediately. The line buffers share rst_n, so no flush is needed.
- States and transitions:
  - IDLE: pix_ready=0, busy=0. start -> FILL.
  - FILL: rows 0..KSIZE-2 are being written; no windows can be produced.
    - Transition to RUN on the accept of the last pixel of row KSIZE-2.
  - RUN: windows are produced.
    - Transition to DONE on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - DONE: lasts one cycle. frame_done=1, pix_ready=0, busy=1. Next state is IDLE.
- Handshake:
  - pix_ready = (state==FILL or RUN), combinational from state.
  - accept = pix_valid & pix_ready.
  - lb_wr_en = accept, combinational, with zero latency.
  - pix_valid when not ready is ignored and produces no write.
  - Gaps in pix_valid stall the counters; all state holds.
- Counters:
  - col increments on accept and wraps to 0 at IMG_WIDTH-1; row increments on that wrap.
  - row_idx and col_idx are registered and show the position of the most recently accepted pixel.
  - Two stride phase counters reset to 0 at col==KSIZE-1 and row==KSIZE-1 respectively. They count modulo STRIDE. No divider is used.
- Window validity:
  - win_valid is registered and asserted the cycle after an accept whose position satisfies all of:
    - row>=KSIZE-1
    - col>=KSIZE-1
    - both stride phases equal 0
  - This aligns win_valid with the window register update on that same edge.
  - Windows per frame = (floor((IMG_WIDTH-KSIZE)/STRIDE)+1) * (floor((IMG_HEIGHT-KSIZE)/STRIDE)+1).
- Simultaneous events:
  - start while busy is ignored.
  - abort has priority over accept in the same cycle. It forces IDLE and clears the counters and win_valid next cycle. No frame_done is produced.
  - start and abort together in IDLE: abort wins and the block stays IDLE.
  - The final pixel accept moves to DONE, and win_valid for that pixel (if qualifying) is asserted in the DONE cycle.
- The line-buffer contents after an abort are stale. The scheduler must pulse rst_n or refill KSIZE-1 rows, which FILL does naturally on the next start.

Decomposition:
- Shared package cnn_pkg:
  - state encoding typedef (IDLE, FILL, RUN, DONE)
  - default IMG_WIDTH/IMG_HEIGHT/KSIZE constants shared with the line buffers
- One natural sub-module: raster_counter.
  - Contains col/row counters with wrap and end-of-row/end-of-frame flags, plus the stride phase counters.
  - Reused later by the output writeback path.

Test Plan:
- IMG_WIDTH=6, IMG_HEIGHT=5, KSIZE=3, STRIDE=1, continuous pix_valid after start:
  - lb_wr_en asserts exactly 30 times.
  - 12 win_valid pulses.
  - First win_valid the cycle after pixel 14 (row 2, col 2).
  - frame_done one cycle after pixel 29.
- Same frame with STRIDE=2: win_valid only for (row,col) in {2,4}x{2,4}, 4 pulses total.
- Random 50% gaps on pix_valid: same 12 windows at identical (row_idx,col_idx), and no lb_wr_en during gaps.
- pix_valid before start, and a start pulse mid-frame: no writes while IDLE, and the frame is unaffected by the second start.
- abort asserted together with pix_valid at pixel 17: that pixel is not written, IDLE the next cycle, row_idx=col_idx=0, and no frame_done.
- rst_n low for 2 cycles at pixel 20, then a new start: outputs are 0 during reset, and the full 12-window frame repeats correctly.
